// File: rtl/fnd_digit_scanner_if.sv
// Scan-control bundle between the FND digit scanner and its consumer:
// run request in, digit select / blank / frame tick out.
interface fnd_digit_scanner_if;
  logic       i_Run;
  logic [1:0] o_DigitSelect;
  logic       o_Blank;
  logic       o_FrameTick;

  modport master (
    output i_Run,
    input  o_DigitSelect,
    input  o_Blank,
    input  o_FrameTick
  );

  modport slave (
    input  i_Run,
    output o_DigitSelect,
    output o_Blank,
    output o_FrameTick
  );
endinterface

// File: rtl/fnd_digit_scanner.sv
// Time-multiplexing scan controller for a 4-digit FND: digit select, blanking, frame tick.
// Define FND_DIGIT_GAP_EN to insert a BLANK_CYCLES blanking gap after every digit slot.
module fnd_digit_scanner #(
  parameter int DIV_COUNT    = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  fnd_digit_scanner_if.slave   bus
);

  localparam int CNT_W = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);

  generate
    if (DIV_COUNT < 2 || BLANK_CYCLES < 1) begin : g_bad_param
      $error("fnd_digit_scanner: DIV_COUNT must be >= 2 and BLANK_CYCLES >= 1");
    end
  endgenerate

`ifdef FND_DIGIT_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;
  localparam int GAP_W = (BLANK_CYCLES > 2) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BLANK_CYCLES - 1);
  logic [GAP_W-1:0] gap_q, gap_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHOW} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic             blank_q, blank_d;
  logic             tick_q, tick_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      digit_q <= 2'd0;
      blank_q <= 1'b1;
      tick_q  <= 1'b0;
`ifdef FND_DIGIT_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      blank_q <= blank_d;
      tick_q  <= tick_d;
`ifdef FND_DIGIT_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  // Pause is evaluated before slot expiry so a dropped run never advances the digit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    blank_d = blank_q;
    tick_d  = 1'b0;
`ifdef FND_DIGIT_GAP_EN
    gap_d   = gap_q;
`endif

    if (!bus.i_Run) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      blank_d = 1'b1;
`ifdef FND_DIGIT_GAP_EN
      gap_d   = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SHOW;
          cnt_d   = '0;
          blank_d = 1'b0;
        end
        S_SHOW: begin
          blank_d = 1'b0;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
            tick_d  = (digit_q == 2'd3);
`ifdef FND_DIGIT_GAP_EN
            state_d = S_GAP;
            blank_d = 1'b1;
            gap_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef FND_DIGIT_GAP_EN
        S_GAP: begin
          blank_d = 1'b1;
          if (gap_q == GAP_LAST) begin
            state_d = S_SHOW;
            blank_d = 1'b0;
            gap_d   = '0;
            cnt_d   = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
`endif
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          blank_d = 1'b1;
        end
      endcase
    end
  end

  assign bus.o_DigitSelect = digit_q;
  assign bus.o_Blank       = blank_q;
  assign bus.o_FrameTick   = tick_q;

endmodule

// File: tb/tb_fnd_digit_scanner.sv
// Directed bench for fnd_digit_scanner (DIV_COUNT=4, BLANK_CYCLES=2); gap tests run when FND_DIGIT_GAP_EN is defined.
module tb_fnd_digit_scanner;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fnd_digit_scanner_if bus ();

  fnd_digit_scanner #(
    .DIV_COUNT    (4),
    .BLANK_CYCLES (2)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.i_Run = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.i_Run = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;

    chk("rst_dig",   32'(bus.o_DigitSelect), 0);
    chk("rst_blank", 32'(bus.o_Blank), 1);
    chk("rst_tick",  32'(bus.o_FrameTick), 0);
    step(1);
    chk("idle_blank", 32'(bus.o_Blank), 1);

    // Asynchronous reset in the middle of digit 2's slot.
    bus.i_Run = 1'b1;
`ifdef FND_DIGIT_GAP_EN
    step(14);
`else
    step(10);
`endif
    chk("t1_pre_dig",   32'(bus.o_DigitSelect), 2);
    chk("t1_pre_blank", 32'(bus.o_Blank), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_dig",   32'(bus.o_DigitSelect), 0);
    chk("t1_blank", 32'(bus.o_Blank), 1);
    chk("t1_tick",  32'(bus.o_FrameTick), 0);
    bus.i_Run = 1'b0;
    step(1);
    rst = 1'b0;

`ifndef FND_DIGIT_GAP_EN
    // Back-to-back scan: 4 cycles per digit, tick on each 3 -> 0 wrap.
    do_reset();
    bus.i_Run = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      chk($sformatf("t2_dig_%0d", k),   32'(bus.o_DigitSelect), 32'(((k - 1) / 4) % 4));
      chk($sformatf("t2_blank_%0d", k), 32'(bus.o_Blank), 0);
      chk($sformatf("t2_tick_%0d", k),  32'(bus.o_FrameTick),
          (k > 1 && ((k - 1) % 16) == 0) ? 32'd1 : 32'd0);
    end

    // Pause two cycles into digit 2, then resume with a full slot.
    do_reset();
    bus.i_Run = 1'b1;
    step(10);
    bus.i_Run = 1'b0;
    step(1);
    chk("t3_pause_blank", 32'(bus.o_Blank), 1);
    chk("t3_pause_dig",   32'(bus.o_DigitSelect), 2);
    step(2);
    chk("t3_hold_dig",    32'(bus.o_DigitSelect), 2);
    bus.i_Run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("t3_res_dig_%0d", i), 32'(bus.o_DigitSelect), (i < 4) ? 32'd2 : 32'd3);
      chk($sformatf("t3_res_blank_%0d", i), 32'(bus.o_Blank), 0);
    end

    // Pause on the expiry cycle of digit 3: no advance, no tick.
    do_reset();
    bus.i_Run = 1'b1;
    step(16);
    chk("t4_pre_dig", 32'(bus.o_DigitSelect), 3);
    bus.i_Run = 1'b0;
    step(1);
    chk("t4_dig",   32'(bus.o_DigitSelect), 3);
    chk("t4_blank", 32'(bus.o_Blank), 1);
    chk("t4_tick",  32'(bus.o_FrameTick), 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk($sformatf("t4_after_tick_%0d", i), 32'(bus.o_FrameTick), 0);
      chk($sformatf("t4_after_dig_%0d", i),  32'(bus.o_DigitSelect), 3);
    end
`else
    // Gap build: 4 shown cycles then 2 blank cycles carrying the next digit.
    do_reset();
    bus.i_Run = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step(1);
      chk($sformatf("t5_dig_%0d", k), 32'(bus.o_DigitSelect),
          32'((((k - 1) / 6) + ((((k - 1) % 6) >= 4) ? 1 : 0)) % 4));
      chk($sformatf("t5_blank_%0d", k), 32'(bus.o_Blank),
          (((k - 1) % 6) >= 4) ? 32'd1 : 32'd0);
      chk($sformatf("t5_tick_%0d", k), 32'(bus.o_FrameTick),
          (((k - 1) % 6) == 4 && (((k - 1) / 6) % 4) == 3) ? 32'd1 : 32'd0);
    end

    // Pause inside the gap after digit 1; resume shows digit 2 for a full slot.
    do_reset();
    bus.i_Run = 1'b1;
    step(11);
    chk("t6_pre_dig",   32'(bus.o_DigitSelect), 2);
    chk("t6_pre_blank", 32'(bus.o_Blank), 1);
    bus.i_Run = 1'b0;
    step(1);
    chk("t6_idle_dig",   32'(bus.o_DigitSelect), 2);
    chk("t6_idle_blank", 32'(bus.o_Blank), 1);
    chk("t6_idle_tick",  32'(bus.o_FrameTick), 0);
    step(2);
    bus.i_Run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("t6_res_dig_%0d", i),   32'(bus.o_DigitSelect), (i < 4) ? 32'd2 : 32'd3);
      chk($sformatf("t6_res_blank_%0d", i), 32'(bus.o_Blank), (i < 4) ? 32'd0 : 32'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
